// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - decode-side handshake and per-stage control outputs of the chain
interface ctrl_pipe_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic [WIDTH-1:0]       in_ctrl;
  logic                   in_valid;
  logic                   in_ready;
  logic [DEPTH*WIDTH-1:0] stage_ctrl;
  logic [DEPTH-1:0]       stage_valid;
  logic [WIDTH-1:0]       out_ctrl;
  logic                   out_valid;

  modport master (
    output in_ctrl, in_valid,
    input  in_ready, stage_ctrl, stage_valid, out_ctrl, out_valid
  );

  modport slave (
    input  in_ctrl, in_valid,
    output in_ready, stage_ctrl, stage_valid, out_ctrl, out_valid
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - DEPTH-stage control word pipeline with per-stage stall/flush
// and saturating stall/flush event counters.
module ctrl_pipe_chain #(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 3,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DEPTH-1:0]      stall_i,
  input  logic [DEPTH-1:0]      flush_i,
  ctrl_pipe_chain_if.slave      pipe_if,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic [DEPTH-1:0]             hold;
  logic [DEPTH-1:0]             up_hold;
  logic [DEPTH-1:0][WIDTH-1:0]  up_ctrl;
  logic [DEPTH-1:0]             up_valid;
  logic [DEPTH-1:0][WIDTH-1:0]  ctrl_d, ctrl_q;
  logic [DEPTH-1:0]             valid_d, valid_q;
  logic [CNT_W-1:0]             stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]             flush_cnt_d, flush_cnt_q;

  // up_* is what each stage would load when advancing; up_hold marks a
  // stall boundary directly upstream, where a bubble must be inserted instead.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign hold[k] = |stall_i[DEPTH-1:k];
    if (k == 0) begin : g_head
      assign up_ctrl[k]  = pipe_if.in_valid ? pipe_if.in_ctrl : BUBBLE;
      assign up_valid[k] = pipe_if.in_valid;
      assign up_hold[k]  = 1'b0;
    end else begin : g_body
      assign up_ctrl[k]  = ctrl_q[k-1];
      assign up_valid[k] = valid_q[k-1];
      assign up_hold[k]  = hold[k-1];
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i[k]) begin
        ctrl_d[k]  = BUBBLE;
        valid_d[k] = 1'b0;
      end else if (!hold[k]) begin
        if (up_hold[k]) begin
          ctrl_d[k]  = BUBBLE;
          valid_d[k] = 1'b0;
        end else begin
          ctrl_d[k]  = up_ctrl[k];
          valid_d[k] = up_valid[k];
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((|stall_i) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if ((|flush_i) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q      <= {DEPTH{BUBBLE}};
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pipe_if.in_ready    = ~hold[0];
  assign pipe_if.stage_ctrl  = ctrl_q;
  assign pipe_if.stage_valid = valid_q;
  assign pipe_if.out_ctrl    = ctrl_q[DEPTH-1];
  assign pipe_if.out_valid   = valid_q[DEPTH-1];
  assign stall_cnt_o         = stall_cnt_q;
  assign flush_cnt_o         = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - directed scoreboard bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [2:0]  stall_a, flush_a, stall_b, flush_b;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  ctrl_pipe_chain_if #(.WIDTH(8), .DEPTH(3)) a_if ();
  ctrl_pipe_chain_if #(.WIDTH(8), .DEPTH(3)) b_if ();

  ctrl_pipe_chain #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00), .CNT_W(16)) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst_a),
    .stall_i     (stall_a),
    .flush_i     (flush_a),
    .pipe_if     (a_if.slave),
    .stall_cnt_o (stall_cnt_a),
    .flush_cnt_o (flush_cnt_a)
  );

  ctrl_pipe_chain #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00), .CNT_W(2)) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst_b),
    .stall_i     (stall_b),
    .flush_i     (flush_b),
    .pipe_if     (b_if.slave),
    .stall_cnt_o (stall_cnt_b),
    .flush_cnt_o (flush_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ready;
    logic [23:0] ctrl;
    logic [2:0]  valid;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [1:0]  bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  // Monitor: state after each edge is compared against the head of the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "in_ready",    {31'd0, a_if.in_ready},    {31'd0, e.ready});
        chk(e.name, "stage_ctrl",  {8'd0, a_if.stage_ctrl},   {8'd0, e.ctrl});
        chk(e.name, "stage_valid", {29'd0, a_if.stage_valid}, {29'd0, e.valid});
        chk(e.name, "out_ctrl",    {24'd0, a_if.out_ctrl},    {24'd0, e.ctrl[23:16]});
        chk(e.name, "out_valid",   {31'd0, a_if.out_valid},   {31'd0, e.valid[2]});
        chk(e.name, "stall_cnt",   {16'd0, stall_cnt_a},      {16'd0, e.scnt});
        chk(e.name, "flush_cnt",   {16'd0, flush_cnt_a},      {16'd0, e.fcnt});
        chk(e.name, "b_stall_cnt", {30'd0, stall_cnt_b},      {30'd0, e.bcnt});
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [7:0] ic, input logic iv,
                      input logic [2:0] st, input logic [2:0] fl, input logic rstb, input logic stb,
                      input logic ready, input logic [23:0] ctrl, input logic [2:0] valid,
                      input logic [15:0] scnt, input logic [15:0] fcnt, input logic [1:0] bcnt);
    exp_t e;
    @(negedge clk);
    rst_a         = rst;
    a_if.in_ctrl  = ic;
    a_if.in_valid = iv;
    stall_a       = st;
    flush_a       = fl;
    rst_b         = rstb;
    stall_b       = {2'b00, stb};
    e.name  = name;
    e.ready = ready;
    e.ctrl  = ctrl;
    e.valid = valid;
    e.scnt  = scnt;
    e.fcnt  = fcnt;
    e.bcnt  = bcnt;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    stall_a = '0; flush_a = '0; stall_b = '0; flush_b = '0;
    a_if.in_ctrl = '0; a_if.in_valid = 1'b0;
    b_if.in_ctrl = '0; b_if.in_valid = 1'b0;

    //    name        rst ic    iv st    fl    rb sb  rdy ctrl{s2,s1,s0} valid  scnt fcnt b
    step("reset",     1, 8'hFF, 1, 3'b000, 3'b000, 1, 0, 1, 24'h000000, 3'b000, 0, 0, 0);
    step("idle",      0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 0, 0, 0);
    step("stream1",   0, 8'h11, 1, 3'b000, 3'b000, 0, 0, 1, 24'h000011, 3'b001, 0, 0, 0);
    step("stream2",   0, 8'h22, 1, 3'b000, 3'b000, 0, 0, 1, 24'h001122, 3'b011, 0, 0, 0);
    step("stream3",   0, 8'h33, 1, 3'b000, 3'b000, 0, 0, 1, 24'h112233, 3'b111, 0, 0, 0);
    step("drain1",    0, 8'h5A, 0, 3'b000, 3'b000, 0, 0, 1, 24'h223300, 3'b110, 0, 0, 0);
    step("drain2",    0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h330000, 3'b100, 0, 0, 0);
    step("drain3",    0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 0, 0, 0);
    step("st_fill1",  0, 8'h44, 1, 3'b000, 3'b000, 0, 0, 1, 24'h000044, 3'b001, 0, 0, 0);
    step("st_fill2",  0, 8'h55, 1, 3'b000, 3'b000, 0, 0, 1, 24'h004455, 3'b011, 0, 0, 0);
    step("stall1_a",  0, 8'h66, 1, 3'b010, 3'b000, 0, 0, 0, 24'h004455, 3'b011, 1, 0, 0);
    step("stall1_b",  0, 8'h66, 1, 3'b010, 3'b000, 0, 0, 0, 24'h004455, 3'b011, 2, 0, 0);
    step("st_rel1",   0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h445500, 3'b110, 2, 0, 0);
    step("st_rel2",   0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h550000, 3'b100, 2, 0, 0);
    step("st_rel3",   0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 2, 0, 0);
    step("fl_fill1",  0, 8'h77, 1, 3'b000, 3'b000, 0, 0, 1, 24'h000077, 3'b001, 2, 0, 0);
    step("fl_fill2",  0, 8'h88, 1, 3'b000, 3'b000, 0, 0, 1, 24'h007788, 3'b011, 2, 0, 0);
    step("flush01",   0, 8'h99, 1, 3'b000, 3'b011, 0, 0, 1, 24'h770000, 3'b100, 2, 1, 0);
    step("fl_after",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 2, 1, 0);
    step("fs_fill1",  0, 8'hAA, 1, 3'b000, 3'b000, 0, 0, 1, 24'h0000AA, 3'b001, 2, 1, 0);
    step("fs_fill2",  0, 8'hBB, 1, 3'b000, 3'b000, 0, 0, 1, 24'h00AABB, 3'b011, 2, 1, 0);
    step("fs_fill3",  0, 8'hCC, 1, 3'b000, 3'b000, 0, 0, 1, 24'hAABBCC, 3'b111, 2, 1, 0);
    step("flst2",     0, 8'hDD, 1, 3'b100, 3'b100, 0, 0, 0, 24'h00BBCC, 3'b011, 3, 2, 0);
    step("flst2_rel", 0, 8'hDD, 1, 3'b000, 3'b000, 0, 0, 1, 24'hBBCCDD, 3'b111, 3, 2, 0);
    step("fl2_st0",   0, 8'hEE, 1, 3'b001, 3'b100, 0, 0, 0, 24'h0000DD, 3'b001, 4, 3, 0);
    step("fl2_rel1",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h00DD00, 3'b010, 4, 3, 0);
    step("fl2_rel2",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'hDD0000, 3'b100, 4, 3, 0);
    step("fl2_rel3",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 4, 3, 0);
    step("sat1",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 1);
    step("sat2",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 2);
    step("sat3",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 3);
    step("sat4",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 3);
    step("sat5",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 3);
    step("sat6",      0, 8'h00, 0, 3'b000, 3'b000, 0, 1, 1, 24'h000000, 3'b000, 4, 3, 3);
    step("sat_rst",   0, 8'h00, 0, 3'b000, 3'b000, 1, 1, 1, 24'h000000, 3'b000, 4, 3, 0);
    step("sat_idle",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 4, 3, 0);
    step("mr_fill1",  0, 8'h12, 1, 3'b000, 3'b000, 0, 0, 1, 24'h000012, 3'b001, 4, 3, 0);
    step("mr_fill2",  0, 8'h34, 1, 3'b000, 3'b000, 0, 0, 1, 24'h001234, 3'b011, 4, 3, 0);
    step("mid_reset", 1, 8'h56, 1, 3'b100, 3'b001, 0, 0, 0, 24'h000000, 3'b000, 0, 0, 0);
    step("post_rst",  0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 1, 24'h000000, 3'b000, 0, 0, 0);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised multi-stage pipeline register chain for decoded control fields. It carries a WIDTH-bit control word plus a valid bit through DEPTH stages, one stage per cycle. Each stage has its own stall and flush input, and the chain inserts bubbles automatically when an upstream stage is held. It replaces the fixed per-stage EX/MEM/WB control registers between decode and writeback, and adds saturating stall and flush event counters for performance debug.

## Interface
- WIDTH, 8, bits per control word
- DEPTH, 3, number of pipeline stages (≥1); stage 0 is the first after decode
- BUBBLE, {WIDTH{1'b0}}, control word loaded for a bubble/NOP (all write/enable bits deasserted)
- CNT_W, 16, width of each event counter
- clock  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- in_ctrl  input  WIDTH  control word from decode
- in_valid  input  1  in_ctrl carries a real instruction
- in_ready  output  1  stage 0 accepts input this cycle
- stall  input  DEPTH  stall[k] freezes stage k and every stage before it
- flush  input  DEPTH  flush[k] turns stage k into a bubble at the next edge
- stage_ctrl  output  DEPTH*WIDTH  stage k's word at bits [k*WIDTH +: WIDTH]
- stage_valid  output  DEPTH  stage k's valid bit
- out_ctrl  output  WIDTH  same as stage DEPTH-1's word
- out_valid  output  1  same as stage_valid[DEPTH-1]
- stall_cnt  output  CNT_W  cycles in which any stall bit was high; saturates
- flush_cnt  output  CNT_W  cycles in which any flush bit was high; saturates

## Operation
- **Hold term.** hold[k] = stall[k] | stall[k+1] | … | stall[DEPTH-1]. A stall anywhere freezes that stage and everything upstream of it.
- **Readiness.** in_ready = ~hold[0], combinational.
- **Per-stage update at each edge, highest priority first:**
  - reset: ctrl = BUBBLE, valid = 0.
  - flush[k]: ctrl = BUBBLE, valid = 0. Flush wins over hold. A flushed stage that is also stalled still holds the stages upstream of it.
  - hold[k]: ctrl and valid are kept.
  - Advance, stage 0: load in_ctrl and in_valid. If in_valid = 0, load BUBBLE instead of in_ctrl.
  - Advance, stage k>0 with hold[k-1] = 0: load stage k-1.
  - Advance, stage k>0 with hold[k-1] = 1: load BUBBLE with valid = 0. This is bubble insertion below a stall boundary.
- **Invariant.** stage_valid[k] = 0 implies the stage word equals BUBBLE, in every cycle.
- **Input while not ready.** When in_ready = 0, in_ctrl and in_valid are ignored. Decode must hold its word and re-present it.
- **Counters.**
  - stall_cnt increments by 1 in each cycle where stall is nonzero.
  - flush_cnt increments by 1 in each cycle where flush is nonzero.
  - Both stick at 2^CNT_W−1 and do not wrap.
  - Both reset to 0.
  - Counting is independent of reset-free operation of the data path.
- **DEPTH = 1.** The single stage obeys the same rules. No bubble-insertion path exists.

## Timing
- **Reset values.** With reset high at an edge, all stage words become BUBBLE, and stage_valid, out_valid, stall_cnt and flush_cnt become 0. in_ready follows stall combinationally, including during reset.
- **Reset mid-operation.** Reset overrides any stall or flush and clears all in-flight entries in one edge.
- **Latency.** With no stall or flush, a word accepted at edge n appears on out_ctrl/out_valid after edge n+DEPTH−1, i.e. stage k after edge n+k.
- **Throughput.** One word per cycle with no stall.
- **Combinational paths.**
  - stall to in_ready is combinational.
  - flush has no combinational path to any output.
  - All other outputs are registered.
- **Simultaneous events.**
  - flush[k] together with stall[j] for j<k: stage k becomes a bubble, stages 0..j hold, and stages j+1..k−1 advance.
  - flush[k] with the k−1 word advancing in the same cycle: that word is discarded and not forwarded.

## Test plan
WIDTH = 8, DEPTH = 3, BUBBLE = 8'h00.
- **Reset.** Drive reset for 1 cycle with junk in_ctrl = 8'hFF, in_valid = 1 → all stages 00, all valid 0, counters 0. On the next cycle in_ready = 1.
- **Streaming.** Present A1, A2, A3 with valid on 3 consecutive cycles, no stall → out_ctrl shows A1, A2, A3 on cycles 3–5 with out_valid = 1. After that out_valid = 0 and out_ctrl = 00.
- **Stall at stage 1 for 2 cycles** with A1 in stage 1 and A2 in stage 0:
  - in_ready = 0 and stages 0–1 hold A2/A1.
  - Stage 2 receives two bubbles (00, valid 0).
  - After release, A1 then A2 exit in order.
  - stall_cnt = 2.
- **Flush stages 0 and 1 together** (e.g. a branch) while stage 2 holds A1 → next cycle stages 0–1 are 00 invalid, A1 still exits, flush_cnt = 1.
- **Flush with stall.** Assert flush[2] and stall[2] together with B in stage 2 → stage 2 becomes 00 invalid, stages 0–1 hold, in_ready = 0.
- **Saturation.** CNT_W = 2 with stall held 6 cycles → stall_cnt reads 1, 2, 3, 3, 3, 3. Reset then returns it to 0.
